// File: rtl/systolic_skew_feeder.sv
// Captures operand matrices A (M x N) and B (N x P) in one handshake and streams them
// diagonally skewed into an M x P systolic grid, with back-pressure, flush and done control.
module systolic_skew_feeder #(
  parameter  int BW          = 16,
  parameter  int M           = 3,
  parameter  int N           = 4,
  parameter  int P           = 5,
  parameter  int B_COL_MAJOR = 0,
  localparam int BR          = (B_COL_MAJOR != 0) ? P : N,
  localparam int BC          = (B_COL_MAJOR != 0) ? N : P
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  output logic                            o_in_ready,
  input  logic [M-1:0][N-1:0][BW-1:0]     i_a,
  input  logic [BR-1:0][BC-1:0][BW-1:0]   i_b,
  input  logic                            i_flush,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [M-1:0][BW-1:0]            o_row,
  output logic [P-1:0][BW-1:0]            o_col,
  output logic                            o_first,
  output logic                            o_last,
  output logic                            o_done,
  output logic                            o_busy
);

  localparam int MAXMP = (M > P) ? M : P;
  localparam int LEN   = N + MAXMP - 1;
  localparam int CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST_T = CW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                       state, nextState;
  logic [CW-1:0]                t, nextT;
  logic [M-1:0][N-1:0][BW-1:0]  aBuf;
  logic [N-1:0][P-1:0][BW-1:0]  bBuf;
  logic [N-1:0][P-1:0][BW-1:0]  bIn;
  logic                         accept;

  // B is always buffered row-major so the skew logic has a single layout to handle
  if (B_COL_MAJOR != 0) begin : gColMajor
    always_comb begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < P; j++)
          bIn[k][j] = i_b[j][k];
    end
  end else begin : gRowMajor
    assign bIn = i_b;
  end

  assign accept = (state == IDLE) && i_start && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= nextState;
      t     <= nextT;
    end
  end

  // Flush leaves the buffers alone; only a fresh accept overwrites them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aBuf <= '0;
      bBuf <= '0;
    end else if (accept) begin
      aBuf <= i_a;
      bBuf <= bIn;
    end
  end

  always_comb begin
    nextState = state;
    nextT     = t;
    if (i_flush) begin
      nextState = IDLE;
      nextT     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            nextState = STREAM;
            nextT     = '0;
          end
        end
        STREAM: begin
          if (i_ready) begin
            if (t == LAST_T) begin
              nextState = DONE;
              nextT     = '0;
            end else begin
              nextT = t + CW'(1);
            end
          end
        end
        DONE: nextState = IDLE;
        default: begin
          nextState = IDLE;
          nextT     = '0;
        end
      endcase
    end
  end

  assign o_in_ready = (state == IDLE);
  assign o_valid    = (state == STREAM);
  assign o_done     = (state == DONE);
  assign o_busy     = (state != IDLE);
  assign o_first    = o_valid && (t == '0);
  assign o_last     = o_valid && (t == LAST_T);

  // Lane i of the row output carries A(i, t-i); lane j of the column output carries B(t-j, j)
  always_comb begin
    o_row = '0;
    o_col = '0;
    if (o_valid) begin
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++)
          if (int'(t) == i + k) o_row[i] = aBuf[i][k];
      for (int j = 0; j < P; j++)
        for (int k = 0; k < N; k++)
          if (int'(t) == j + k) o_col[j] = bBuf[k][j];
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench: row-major and column-major feeders share stimulus and are both
// checked against one queue of expected beats built from the bench's own matrices.
module tb_systolic_skew_feeder;

  localparam int BW  = 16;
  localparam int M   = 3;
  localparam int N   = 4;
  localparam int P   = 5;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iStart = 1'b0;
  logic iFlush = 1'b0;
  logic iReady = 1'b1;
  logic [M-1:0][N-1:0][BW-1:0] iA;
  logic [N-1:0][P-1:0][BW-1:0] iB;
  logic [P-1:0][N-1:0][BW-1:0] iBT;

  logic inReady0, valid0, first0, last0, done0, busy0;
  logic inReady1, valid1, first1, last1, done1, busy1;
  logic [M-1:0][BW-1:0] row0, row1;
  logic [P-1:0][BW-1:0] col0, col1;

  typedef struct {
    logic [M-1:0][BW-1:0] row;
    logic [P-1:0][BW-1:0] col;
    logic                 first;
    logic                 last;
    int                   t;
  } beat_t;

  beat_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int beatsSeen = 0;
  int holdCnt = 0;
  int bpBeat = -1;
  bit expectDone = 1'b0;
  bit monEn = 1'b0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.BW(BW), .M(M), .N(N), .P(P), .B_COL_MAJOR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(iStart), .o_in_ready(inReady0),
    .i_a(iA), .i_b(iB), .i_flush(iFlush), .o_valid(valid0), .i_ready(iReady),
    .o_row(row0), .o_col(col0), .o_first(first0), .o_last(last0),
    .o_done(done0), .o_busy(busy0));

  systolic_skew_feeder #(.BW(BW), .M(M), .N(N), .P(P), .B_COL_MAJOR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(iStart), .o_in_ready(inReady1),
    .i_a(iA), .i_b(iBT), .i_flush(iFlush), .o_valid(valid1), .i_ready(iReady),
    .o_row(row1), .o_col(col1), .o_first(first1), .o_last(last1),
    .o_done(done1), .o_busy(busy1));

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A(i,k) = 16i+k+1+ofs, B(k,j) = 16k+j+0x81; the transposed copy feeds the column-major unit
  function automatic void setMatrices(input int ofs);
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++)
        iA[i][k] = 16'(16 * i + k + 1 + ofs);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < P; j++) begin
        iB[k][j]  = 16'(16 * k + j + 'h81);
        iBT[j][k] = 16'(16 * k + j + 'h81);
      end
  endfunction

  task automatic applyStimulus();
    beat_t e;
    for (int t = 0; t < LEN; t++) begin
      e.row   = '0;
      e.col   = '0;
      e.first = (t == 0);
      e.last  = (t == LEN - 1);
      e.t     = t;
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++)
          if (t == i + k) e.row[i] = iA[i][k];
      for (int j = 0; j < P; j++)
        for (int k = 0; k < N; k++)
          if (t == j + k) e.col[j] = iB[k][j];
      sb.push_back(e);
    end
    beatsSeen = 0;
    holdCnt   = 0;
    iStart    = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
  endtask

  task automatic waitBeats(input int k);
    int n = 0;
    while (beatsSeen < k) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        checkOutput("waitBeats", 128'(beatsSeen), 128'(k));
        break;
      end
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (sb.size() == 0 && inReady0 && !busy0) break;
      n++;
      if (n > 200) begin
        checkOutput("waitIdle", 128'(busy0), 128'(0));
        break;
      end
    end
  endtask

  // Compares every presented beat against the queue head; pops only on an accepted beat
  always @(negedge clk) begin
    beat_t e;
    if (monEn) begin
      checkOutput("done0", 128'(done0), 128'(expectDone));
      checkOutput("done1", 128'(done1), 128'(expectDone));
      expectDone = 1'b0;
      checkOutput("valid1", 128'(valid1), 128'(valid0));
      if (valid0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedBeat", 128'(valid0), 128'(0));
        end else begin
          e = sb[0];
          checkOutput($sformatf("row0 t%0d", e.t), 128'(row0), 128'(e.row));
          checkOutput($sformatf("col0 t%0d", e.t), 128'(col0), 128'(e.col));
          checkOutput($sformatf("row1 t%0d", e.t), 128'(row1), 128'(e.row));
          checkOutput($sformatf("col1 t%0d", e.t), 128'(col1), 128'(e.col));
          checkOutput($sformatf("firstLast t%0d", e.t), {first0, last0, first1, last1},
                      {e.first, e.last, e.first, e.last});
          holdCnt++;
          if (iReady && !iFlush) begin
            void'(sb.pop_front());
            beatsSeen++;
            if (e.t == bpBeat) checkOutput("bpHoldCycles", 128'(holdCnt), 128'(4));
            holdCnt    = 0;
            expectDone = e.last;
          end
        end
      end else begin
        checkOutput("idleLanes", {row0, col0, first0, last0}, 128'(0));
      end
    end
  end

  initial begin
    setMatrices(0);
    iStart = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 128'(inReady0), 128'(1));
    checkOutput("rstCtl", {valid0, busy0, done0, first0, last0}, 128'(0));
    checkOutput("rstLanes", {row0, col0}, 128'(0));
    @(posedge clk); #1;
    iStart = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checkOutput("noAcceptInReset", {valid0, busy0, valid1, busy1}, 128'(0));
    monEn = 1'b1;
    @(posedge clk); #1;

    applyStimulus();
    waitIdle();
    checkOutput("beatsFull", 128'(beatsSeen), 128'(LEN));

    bpBeat = 2;
    applyStimulus();
    waitBeats(2);
    iReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 iReady = 1'b1;
    waitIdle();
    bpBeat = -1;
    checkOutput("beatsBackPressure", 128'(beatsSeen), 128'(LEN));

    applyStimulus();
    waitBeats(1);
    iStart = 1'b1;
    setMatrices(7);
    @(posedge clk); #1;
    iStart = 1'b0;
    waitBeats(LEN);
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    @(negedge clk);
    checkOutput("startIgnoredInDone", {valid0, busy0, inReady0}, 128'(1));
    @(posedge clk); #1;

    setMatrices(0);
    applyStimulus();
    waitBeats(5);
    iFlush = 1'b1;
    @(posedge clk); #1;
    iFlush = 1'b0;
    sb.delete();
    holdCnt = 0;
    @(negedge clk);
    checkOutput("flushIdle", {valid0, busy0, inReady0}, 128'(1));
    repeat (2) @(posedge clk);
    #1;

    iFlush = 1'b1;
    iStart = 1'b1;
    @(posedge clk); #1;
    iFlush = 1'b0;
    iStart = 1'b0;
    @(negedge clk);
    checkOutput("flushBlocksStart", {valid0, busy0, inReady0}, 128'(1));
    @(posedge clk); #1;

    applyStimulus();
    waitIdle();
    checkOutput("beatsRestart", 128'(beatsSeen), 128'(LEN));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
